// File: rtl/hazard_ctrl.sv
`timescale 1ns/1ps
// hazard_ctrl
// Pipeline hazard controller for the five-stage MIPS core (F/D/E/M/W).
// Decodes the D-stage instruction into operand-use times (Tuse) and
// result-ready times (Tnew). Tracks in-flight destinations through E/M/W.
// Drives the stall and forwarding selects.
//
// Optional build macro: HAZARD_MDU_EN adds the multiply/divide class
// (mult/multu/div/divu/mthi/mtlo/mfhi/mflo) and the mdu_busy interlock.
// When it is undefined, those opcodes decode as undefined and mdu_busy
// is ignored.
//
// Parameters:
//   ADDR_W  register address width (5)
//   TNEW_W  Tnew counter width; must be able to hold 2
// Ports:
//   clk       pipeline clock, rising edge
//   reset     asynchronous, active-high
//   instr_D   instruction currently in D
//   mdu_busy  MDU busy, including its start cycle in E
//   stall     freezes PC and F/D, inserts a bubble into E
//   fwd_rs_D, fwd_rt_D  D comparator/jr source: 0 RF, 1 E result, 2 M result
//   fwd_rs_E, fwd_rt_E  ALU operand source: 0 pipe reg, 1 M result, 2 W result
//   fwd_rt_M  store data source: 0 pipe reg, 1 W result
//   wa_E, wa_M, wa_W  tracked write address per stage (0 = no write)
module hazard_ctrl #(
    parameter int ADDR_W = 5,
    parameter int TNEW_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr_D,
    input  logic              mdu_busy,
    output logic              stall,
    output logic [1:0]        fwd_rs_D,
    output logic [1:0]        fwd_rt_D,
    output logic [1:0]        fwd_rs_E,
    output logic [1:0]        fwd_rt_E,
    output logic              fwd_rt_M,
    output logic [ADDR_W-1:0] wa_E,
    output logic [ADDR_W-1:0] wa_M,
    output logic [ADDR_W-1:0] wa_W
);

    typedef enum logic [1:0] {
        TUSE_D    = 2'd0,
        TUSE_E    = 2'd1,
        TUSE_M    = 2'd2,
        TUSE_NONE = 2'd3
    } tuse_t;

    logic [5:0]        op;
    logic [5:0]        funct;
    logic [ADDR_W-1:0] f_rs;
    logic [ADDR_W-1:0] f_rt;
    logic [ADDR_W-1:0] f_rd;

    tuse_t             tuse_rs;
    tuse_t             tuse_rt;
    logic [ADDR_W-1:0] src_rs;
    logic [ADDR_W-1:0] src_rt;
    logic [ADDR_W-1:0] dec_wa;
    logic [TNEW_W-1:0] dec_tnew;
    logic              mdu_stall;

    logic [ADDR_W-1:0] e_rs;
    logic [ADDR_W-1:0] e_rt;
    logic [ADDR_W-1:0] e_wa;
    logic [TNEW_W-1:0] e_tnew;
    logic [ADDR_W-1:0] m_rt;
    logic [ADDR_W-1:0] m_wa;
    logic [TNEW_W-1:0] m_tnew;
    logic [ADDR_W-1:0] w_wa;

    logic              unused_shamt;

    assign op     = instr_D[31:26];
    assign funct  = instr_D[5:0];
    assign f_rs   = ADDR_W'(instr_D[25:21]);
    assign f_rt   = ADDR_W'(instr_D[20:16]);
    assign f_rd   = ADDR_W'(instr_D[15:11]);
    assign unused_shamt = ^instr_D[10:6];

`ifdef HAZARD_MDU_EN
    logic dec_mdu;
`else
    logic unused_mdu;
`endif

    // D-stage decode into Tuse / write address / Tnew
    always_comb begin
        tuse_rs  = TUSE_NONE;
        tuse_rt  = TUSE_NONE;
        dec_wa   = '0;
        dec_tnew = '0;
`ifdef HAZARD_MDU_EN
        dec_mdu  = 1'b0;
`endif
        case (op)
            6'h00: begin
                case (funct)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h2b: begin
                        tuse_rs  = TUSE_E;
                        tuse_rt  = TUSE_E;
                        dec_wa   = f_rd;
                        dec_tnew = TNEW_W'(1);
                    end
                    6'h08: tuse_rs = TUSE_D;
`ifdef HAZARD_MDU_EN
                    6'h18, 6'h19, 6'h1a, 6'h1b: begin
                        tuse_rs = TUSE_E;
                        tuse_rt = TUSE_E;
                        dec_mdu = 1'b1;
                    end
                    6'h11, 6'h13: begin
                        tuse_rs = TUSE_E;
                        dec_mdu = 1'b1;
                    end
                    6'h10, 6'h12: begin
                        dec_wa   = f_rd;
                        dec_tnew = TNEW_W'(1);
                        dec_mdu  = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
            6'h08, 6'h0c, 6'h0d, 6'h0f: begin
                tuse_rs  = TUSE_E;
                dec_wa   = f_rt;
                dec_tnew = TNEW_W'(1);
            end
            6'h23, 6'h21, 6'h20: begin
                tuse_rs  = TUSE_E;
                dec_wa   = f_rt;
                dec_tnew = TNEW_W'(2);
            end
            6'h2b, 6'h29, 6'h28: begin
                tuse_rs = TUSE_E;
                tuse_rt = TUSE_M;
            end
            6'h04, 6'h05: begin
                tuse_rs = TUSE_D;
                tuse_rt = TUSE_D;
            end
            6'h03: begin
                dec_wa   = ADDR_W'(5'd31);
                dec_tnew = '0;
            end
            default: ;
        endcase
        // A write to $0 is no write at all; drop its Tnew so nothing waits on it.
        if (dec_wa == '0) begin
            dec_tnew = '0;
        end
    end

    // Only sources the instruction really reads are tracked, so unused
    // fields can never raise a stall or a forward.
    assign src_rs = (tuse_rs != TUSE_NONE) ? f_rs : '0;
    assign src_rt = (tuse_rt != TUSE_NONE) ? f_rt : '0;

`ifdef HAZARD_MDU_EN
    assign mdu_stall = dec_mdu & mdu_busy;
`else
    assign mdu_stall  = 1'b0;
    assign unused_mdu = mdu_busy;
`endif

    function automatic logic src_hazard(
        input logic [ADDR_W-1:0] s,
        input tuse_t             tu,
        input logic [ADDR_W-1:0] wae,
        input logic [TNEW_W-1:0] tne,
        input logic [ADDR_W-1:0] wam,
        input logic [TNEW_W-1:0] tnm
    );
        logic hit_e;
        logic hit_m;
        hit_e = (s == wae) && (int'(tu) < int'(tne));
        hit_m = (s == wam) && (int'(tu) < int'(tnm));
        return (s != '0) && (tu != TUSE_NONE) && (hit_e || hit_m);
    endfunction

    function automatic logic [1:0] sel_d(
        input logic [ADDR_W-1:0] s,
        input logic [ADDR_W-1:0] wae,
        input logic [TNEW_W-1:0] tne,
        input logic [ADDR_W-1:0] wam,
        input logic [TNEW_W-1:0] tnm
    );
        if (s == '0)                       return 2'd0;
        else if (s == wae && tne == '0)    return 2'd1;
        else if (s == wam && tnm == '0)    return 2'd2;
        else                               return 2'd0;
    endfunction

    function automatic logic [1:0] sel_e(
        input logic [ADDR_W-1:0] s,
        input logic [ADDR_W-1:0] wam,
        input logic [TNEW_W-1:0] tnm,
        input logic [ADDR_W-1:0] waw
    );
        if (s == '0)                       return 2'd0;
        else if (s == wam && tnm == '0)    return 2'd1;
        else if (s == waw)                 return 2'd2;
        else                               return 2'd0;
    endfunction

    // Outputs are forced low while reset is held so a stall cannot
    // survive into the reset cycle, whatever sits in D.
    always_comb begin
        stall    = 1'b0;
        fwd_rs_D = 2'd0;
        fwd_rt_D = 2'd0;
        fwd_rs_E = 2'd0;
        fwd_rt_E = 2'd0;
        fwd_rt_M = 1'b0;
        if (!reset) begin
            stall = src_hazard(src_rs, tuse_rs, e_wa, e_tnew, m_wa, m_tnew)
                  | src_hazard(src_rt, tuse_rt, e_wa, e_tnew, m_wa, m_tnew)
                  | mdu_stall;
            fwd_rs_D = sel_d(src_rs, e_wa, e_tnew, m_wa, m_tnew);
            fwd_rt_D = sel_d(src_rt, e_wa, e_tnew, m_wa, m_tnew);
            fwd_rs_E = sel_e(e_rs, m_wa, m_tnew, w_wa);
            fwd_rt_E = sel_e(e_rt, m_wa, m_tnew, w_wa);
            fwd_rt_M = (m_rt != '0) && (m_rt == w_wa);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_rs   <= '0;
            e_rt   <= '0;
            e_wa   <= '0;
            e_tnew <= '0;
            m_rt   <= '0;
            m_wa   <= '0;
            m_tnew <= '0;
            w_wa   <= '0;
        end else begin
            if (stall) begin
                e_rs   <= '0;
                e_rt   <= '0;
                e_wa   <= '0;
                e_tnew <= '0;
            end else begin
                e_rs   <= src_rs;
                e_rt   <= src_rt;
                e_wa   <= dec_wa;
                e_tnew <= dec_tnew;
            end
            m_rt   <= e_rt;
            m_wa   <= e_wa;
            m_tnew <= (e_tnew == '0) ? '0 : e_tnew - TNEW_W'(1);
            w_wa   <= m_wa;
        end
    end

    assign wa_E = e_wa;
    assign wa_M = m_wa;
    assign wa_W = w_wa;

endmodule

// File: tb/tb_hazard_ctrl.sv
`timescale 1ns/1ps
// tb_hazard_ctrl
// Directed sequences for hazard_ctrl. Each driven cycle pushes its expected
// outputs to a queue; the negedge monitor pops and compares them.
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] instr_D;
    logic        mdu_busy;
    logic        stall;
    logic [1:0]  fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
    logic        fwd_rt_M;
    logic [4:0]  wa_E, wa_M, wa_W;

    hazard_ctrl #(.ADDR_W(5), .TNEW_W(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .instr_D  (instr_D),
        .mdu_busy (mdu_busy),
        .stall    (stall),
        .fwd_rs_D (fwd_rs_D),
        .fwd_rt_D (fwd_rt_D),
        .fwd_rs_E (fwd_rs_E),
        .fwd_rt_E (fwd_rt_E),
        .fwd_rt_M (fwd_rt_M),
        .wa_E     (wa_E),
        .wa_M     (wa_M),
        .wa_W     (wa_W)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef HAZARD_MDU_EN
    localparam logic       MS = 1'b1;
    localparam logic [4:0] MW = 5'd4;
`else
    localparam logic       MS = 1'b0;
    localparam logic [4:0] MW = 5'd0;
`endif

    localparam logic [31:0] I_NOP   = 32'd0;
    localparam logic [31:0] I_ORI1  = {6'h0d, 5'd0, 5'd1, 16'd5};
    localparam logic [31:0] I_ADD2  = {6'h00, 5'd1, 5'd1, 5'd2, 5'd0, 6'h20};
    localparam logic [31:0] I_LW1   = {6'h23, 5'd0, 5'd1, 16'd0};
    localparam logic [31:0] I_BEQ10 = {6'h04, 5'd1, 5'd0, 16'd0};
    localparam logic [31:0] I_JAL   = {6'h03, 26'd4};
    localparam logic [31:0] I_JR31  = {6'h00, 5'd31, 15'd0, 6'h08};
    localparam logic [31:0] I_ORI0  = {6'h0d, 5'd0, 5'd0, 16'd7};
    localparam logic [31:0] I_ADD3  = {6'h00, 5'd0, 5'd0, 5'd3, 5'd0, 6'h20};
    localparam logic [31:0] I_SW    = {6'h2b, 5'd2, 5'd1, 16'd0};
    localparam logic [31:0] I_MFLO4 = {6'h00, 10'd0, 5'd4, 5'd0, 6'h12};
    localparam logic [31:0] I_ADD21 = {6'h00, 5'd1, 5'd0, 5'd2, 5'd0, 6'h20};
    localparam logic [31:0] I_ORI5  = {6'h0d, 5'd0, 5'd5, 16'd1};
    localparam logic [31:0] I_BEQ55 = {6'h04, 5'd5, 5'd5, 16'd0};
    localparam logic [31:0] I_ORI3  = {6'h0d, 5'd0, 5'd3, 16'd1};

    typedef struct {
        int         id;
        logic       st;
        logic [1:0] rsd, rtd, rse, rte;
        logic       rtm;
        logic [4:0] wae, wam, waw;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   step_id = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic [31:0] ins, input logic busy, input logic st,
                        input logic [1:0] rsd, input logic [1:0] rtd,
                        input logic [1:0] rse, input logic [1:0] rte, input logic rtm,
                        input logic [4:0] wae, input logic [4:0] wam, input logic [4:0] waw);
        exp_t e;
        instr_D  = ins;
        mdu_busy = busy;
        e.id  = step_id;
        e.st  = st;
        e.rsd = rsd;
        e.rtd = rtd;
        e.rse = rse;
        e.rte = rte;
        e.rtm = rtm;
        e.wae = wae;
        e.wam = wam;
        e.waw = waw;
        sb.push_back(e);
        step_id++;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("c%0d stall", e.id),    32'(stall),    32'(e.st));
            check($sformatf("c%0d fwd_rs_D", e.id), 32'(fwd_rs_D), 32'(e.rsd));
            check($sformatf("c%0d fwd_rt_D", e.id), 32'(fwd_rt_D), 32'(e.rtd));
            check($sformatf("c%0d fwd_rs_E", e.id), 32'(fwd_rs_E), 32'(e.rse));
            check($sformatf("c%0d fwd_rt_E", e.id), 32'(fwd_rt_E), 32'(e.rte));
            check($sformatf("c%0d fwd_rt_M", e.id), 32'(fwd_rt_M), 32'(e.rtm));
            check($sformatf("c%0d wa_E", e.id),     32'(wa_E),     32'(e.wae));
            check($sformatf("c%0d wa_M", e.id),     32'(wa_M),     32'(e.wam));
            check($sformatf("c%0d wa_W", e.id),     32'(wa_W),     32'(e.waw));
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, " stall"},    32'(stall),    32'd0);
        check({tag, " fwd_rs_D"}, 32'(fwd_rs_D), 32'd0);
        check({tag, " fwd_rt_D"}, 32'(fwd_rt_D), 32'd0);
        check({tag, " fwd_rs_E"}, 32'(fwd_rs_E), 32'd0);
        check({tag, " fwd_rt_E"}, 32'(fwd_rt_E), 32'd0);
        check({tag, " fwd_rt_M"}, 32'(fwd_rt_M), 32'd0);
        check({tag, " wa_E"},     32'(wa_E),     32'd0);
        check({tag, " wa_M"},     32'(wa_M),     32'd0);
        check({tag, " wa_W"},     32'(wa_W),     32'd0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state; an MDU instruction with mdu_busy must not leak a stall.
        reset    = 1'b1;
        instr_D  = I_MFLO4;
        mdu_busy = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("reset");
        reset    = 1'b0;
        instr_D  = I_NOP;
        mdu_busy = 1'b0;

        // ori $1 ; add $2,$1,$1 : no stall, M forwarding to both ALU operands
        step(I_ORI1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(I_ADD2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(I_NOP,  0, 0, 0, 0, 1, 1, 0, 2, 1, 0);
        step(I_NOP,  0, 0, 0, 0, 0, 0, 1, 0, 2, 1);
        step(I_NOP,  0, 0, 0, 0, 0, 0, 0, 0, 0, 2);

        // lw $1 ; beq $1,$0 : two stall bubbles, then RF supplies via W
        step(I_LW1,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(I_BEQ10, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        step(I_BEQ10, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        step(I_BEQ10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(I_NOP,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // jal ; jr $31 : E forward into D, then M forward into E
        step(I_JAL,  0, 0, 0, 0, 0, 0, 0, 0,  0,  0);
        step(I_JR31, 0, 0, 1, 0, 0, 0, 0, 31, 0,  0);
        step(I_NOP,  0, 0, 0, 0, 1, 0, 0, 0,  31, 0);
        step(I_NOP,  0, 0, 0, 0, 0, 0, 0, 0,  0,  31);

        // ori $0 ; add $3,$0,$0 : writes to $0 vanish, $0 never forwarded
        step(I_ORI0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(I_ADD3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(I_NOP,  0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        step(I_NOP,  0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        step(I_NOP,  0, 0, 0, 0, 0, 0, 0, 0, 0, 3);

        // lw $1 ; sw $1,0($2) : no stall, W forward of store data in M
        step(I_LW1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(I_SW,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(I_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(I_NOP, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);

        // lw $1 ; add $2,$1,$0 : one stall, then W forward into E
        step(I_LW1,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(I_ADD21, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        step(I_ADD21, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(I_NOP,   0, 0, 0, 0, 2, 0, 0, 2, 0, 1);
        step(I_NOP,   0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
        step(I_NOP,   0, 0, 0, 0, 0, 0, 0, 0, 0, 2);

        // ori $5 ; nop ; beq $5,$5 : M forward into D, W forward into E
        step(I_ORI5,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(I_NOP,   0, 0, 0, 0, 0, 0, 0, 5, 0, 0);
        step(I_BEQ55, 0, 0, 2, 2, 0, 0, 0, 0, 5, 0);
        step(I_NOP,   0, 0, 0, 0, 2, 2, 0, 0, 0, 5);
        step(I_NOP,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // MDU interlock: busy alone does nothing; mflo waits 5 busy cycles
        step(I_NOP,   1, 0,  0, 0, 0, 0, 0, 0,  0,  0);
        for (int i = 0; i < 5; i++) begin
            step(I_MFLO4, 1, MS, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        step(I_MFLO4, 0, 0,  0, 0, 0, 0, 0, 0,  0,  0);
        step(I_NOP,   0, 0,  0, 0, 0, 0, 0, MW, 0,  0);
        step(I_NOP,   0, 0,  0, 0, 0, 0, 0, 0,  MW, 0);
        step(I_NOP,   0, 0,  0, 0, 0, 0, 0, 0,  0,  MW);

        // Reset asserted in the middle of a load-use stall
        step(I_ORI3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(I_LW1,  0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        instr_D = I_BEQ10;
        #1;
        check("pre_reset stall", 32'(stall), 32'd1);
        check("pre_reset wa_E",  32'(wa_E),  32'd1);
        check("pre_reset wa_M",  32'(wa_M),  32'd3);
        #1;
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(I_BEQ10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(I_NOP,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
